gb_frame_ctrl: RTL

Frame-level controller between the gray-balance stream decoder output and the gray-balance core input. It passes video data packets through with zero latency and enforces frame geometry against the decoded width and height. It applies gain coefficients only at frame boundaries, and starts and stops the video path cleanly on frame edges. It also reports frame completion and malformed-frame errors to the host-side register block.

---
 rtl/gb_frame_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gb_frame_ctrl.sv
// Frame-level controller between the gray-balance stream decoder and the core.
// Zero-latency pass-through with per-axis geometry checks, frame-edge coefficient swaps and sticky errors.
module gb_frame_ctrl #(
    parameter int                    DATA_WIDTH = 14,
    parameter int                    COEF_WIDTH = 16,
    parameter logic [COEF_WIDTH-1:0] COEF_RESET = 16'h4000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    input  logic [15:0]           im_width,
    input  logic [15:0]           im_height,
    input  logic                  go,
    input  logic [COEF_WIDTH-1:0] coef_in,
    input  logic                  coef_load,
    output logic [COEF_WIDTH-1:0] coef_active,
    input  logic                  err_clr,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_size,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_WAIT_SOP = 4'b0010,
        S_RUN      = 4'b0100,
        S_DISCARD  = 4'b1000
    } state_t;

    state_t                r_state;
    logic [15:0]           r_w;
    logic [15:0]           r_h;
    logic [15:0]           r_x;
    logic [15:0]           r_y;
    logic [COEF_WIDTH-1:0] r_coef_pend;
    logic [COEF_WIDTH-1:0] r_coef_active;
    logic                  r_err_short;
    logic                  r_err_long;
    logic                  r_err_size;
    logic                  r_frame_done;
    logic [15:0]           r_frame_cnt;

    logic        w_size_ok;
    logic        w_sop_fwd;
    logic        w_fwd;
    logic        w_acc;
    logic        w_x_wrap;
    logic        w_last;
    logic [15:0] w_xc;
    logic [15:0] w_yc;
    logic [15:0] w_wc;
    logic [15:0] w_hc;

    assign w_size_ok = (im_width != 16'd0) && (im_height != 16'd0);
    assign w_sop_fwd = (r_state == S_WAIT_SOP) && din_startofpacket && go && w_size_ok;
    assign w_fwd     = w_sop_fwd || (r_state == S_RUN);

    // The SOP beat is pixel (0,0) of a frame sized by the live im_* inputs.
    assign w_xc     = w_sop_fwd ? 16'd0 : r_x;
    assign w_yc     = w_sop_fwd ? 16'd0 : r_y;
    assign w_wc     = w_sop_fwd ? im_width : r_w;
    assign w_hc     = w_sop_fwd ? im_height : r_h;
    assign w_x_wrap = (w_xc == w_wc - 16'd1);
    assign w_last   = w_x_wrap && (w_yc == w_hc - 16'd1);

    assign din_ready          = w_fwd ? dout_ready : 1'b1;
    assign w_acc              = din_valid && din_ready;
    assign dout_data          = din_data;
    assign dout_valid         = w_fwd && din_valid;
    assign dout_startofpacket = w_sop_fwd;
    assign dout_endofpacket   = w_fwd && (din_endofpacket || w_last);

    assign coef_active = r_coef_active;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;
    assign err_size    = r_err_size;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_w           <= 16'd0;
            r_h           <= 16'd0;
            r_x           <= 16'd0;
            r_y           <= 16'd0;
            r_coef_pend   <= COEF_RESET;
            r_coef_active <= COEF_RESET;
            r_err_short   <= 1'b0;
            r_err_long    <= 1'b0;
            r_err_size    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_frame_done <= 1'b0;
            if (coef_load) begin
                r_coef_pend <= coef_in;
            end
            // Clears come first so a same-cycle set below overrides them.
            if (err_clr) begin
                r_err_short <= 1'b0;
                r_err_long  <= 1'b0;
                r_err_size  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state <= S_WAIT_SOP;
                    end
                end
                S_WAIT_SOP: begin
                    if (w_acc && din_startofpacket && !w_sop_fwd) begin
                        if (!go) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_err_size <= 1'b1;
                            if (!din_endofpacket) begin
                                r_state <= S_DISCARD;
                            end
                        end
                    end
                end
                S_RUN: begin
                end
                S_DISCARD: begin
                    if (w_acc && din_endofpacket) begin
                        r_state <= go ? S_WAIT_SOP : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_fwd && w_acc) begin
                if (w_sop_fwd) begin
                    r_w           <= im_width;
                    r_h           <= im_height;
                    r_coef_active <= coef_load ? coef_in : r_coef_pend;
                end
                if (w_last) begin
                    if (din_endofpacket) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 16'd1;
                        r_state      <= go ? S_WAIT_SOP : S_IDLE;
                    end else begin
                        r_err_long <= 1'b1;
                        r_state    <= S_DISCARD;
                    end
                end else if (din_endofpacket) begin
                    r_err_short <= 1'b1;
                    r_state     <= go ? S_WAIT_SOP : S_IDLE;
                end else begin
                    r_state <= S_RUN;
                    if (w_x_wrap) begin
                        r_x <= 16'd0;
                        r_y <= w_yc + 16'd1;
                    end else begin
                        r_x <= w_xc + 16'd1;
                        r_y <= w_yc;
                    end
                end
            end
        end
    end

endmodule
